// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: upstream ALU-result handshake and downstream writeback handshake
interface alu_result_buffer_if #(parameter int N = 64);
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_sel;
  logic [N-1:0] result;
  logic [N-1:0] upper_result;
  logic         carry_flag;
  logic         overflow_flag;
  logic         zero_flag;
  logic         negative_flag;
  logic         parity_flag;
  logic         modulo_flag;
  logic         sign_flag;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_sel;
  logic [N-1:0] out_result;
  logic [N-1:0] out_upper;
  logic [6:0]   out_flags;
  modport master (
    output in_valid, in_sel, result, upper_result, carry_flag, overflow_flag, zero_flag,
           negative_flag, parity_flag, modulo_flag, sign_flag, out_ready,
    input  in_ready, out_valid, out_sel, out_result, out_upper, out_flags
  );
  modport slave (
    input  in_valid, in_sel, result, upper_result, carry_flag, overflow_flag, zero_flag,
           negative_flag, parity_flag, modulo_flag, sign_flag, out_ready,
    output in_ready, out_valid, out_sel, out_result, out_upper, out_flags
  );
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: DEPTH-entry in-order FIFO of ALU results/flags/opcode; sticky flag register built when ALU_STICKY_FLAGS_EN is defined
module alu_result_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_buffer_if.slave       bus,
  input  logic                     sticky_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [6:0]               sticky_flags
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [5:0]    sel_q [DEPTH];
  logic [N-1:0]  res_q [DEPTH];
  logic [N-1:0]  up_q  [DEPTH];
  logic [6:0]    flg_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  logic [6:0]    in_flags;
  assign in_flags = {bus.sign_flag, bus.modulo_flag, bus.parity_flag, bus.negative_flag,
                     bus.zero_flag, bus.overflow_flag, bus.carry_flag};
  assign bus.in_ready  = cnt_q != FULL;
  assign bus.out_valid = cnt_q != '0;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  assign count         = cnt_q;
  assign bus.out_sel    = sel_q[rd_q];
  assign bus.out_result = res_q[rd_q];
  assign bus.out_upper  = up_q[rd_q];
  assign bus.out_flags  = flg_q[rd_q];
  // occupancy moves only when exactly one of push/pop happens
  always_comb
    cnt_d = (push & ~pop) ? cnt_q + 1'b1 : (pop & ~push) ? cnt_q - 1'b1 : cnt_q;
  // pointers, occupancy and entry storage; reset clears storage so outputs read zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i] <= '0;
        res_q[i] <= '0;
        up_q[i]  <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wr_q        <= wr_q + 1'b1;
        sel_q[wr_q] <= bus.in_sel;
        res_q[wr_q] <= bus.result;
        up_q[wr_q]  <= bus.upper_result;
        flg_q[wr_q] <= in_flags;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
`ifdef ALU_STICKY_FLAGS_EN
  logic [6:0] sticky_q, sticky_d;
  // clear drops history; a push in the same cycle still contributes its flags
  always_comb
    sticky_d = (sticky_clr ? 7'd0 : sticky_q) | (push ? in_flags : 7'd0);
  // sticky accumulation register
  always_ff @(posedge clk or posedge rst)
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = '0;
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: randomized and directed checks of alu_result_buffer against a queue model
module tb_alu_result_buffer;
  localparam int N = 64;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [5:0]   sel;
    logic [N-1:0] r;
    logic [N-1:0] u;
    logic [6:0]   f;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  logic sticky_clr = 0;
  logic [$clog2(DEPTH):0] count;
  logic [6:0] sticky_flags;
  int n_chk = 0;
  int n_err = 0;
  alu_result_buffer_if #(.N(N)) b ();
  alu_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(b), .sticky_clr(sticky_clr),
    .count(count), .sticky_flags(sticky_flags)
  );
  always #5 clk = ~clk;
  ent_t q[$];
  logic [6:0] st = 0;
  bit taken = 0;
  bit m_push, m_pop;
  ent_t m_e;
  // model: a plain queue; push decided from occupancy before any same-cycle pop
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      st = 0;
      taken = 0;
    end else begin
      m_push = b.in_valid && q.size() != DEPTH;
      m_pop  = b.out_ready && q.size() != 0;
      m_e = '{sel: b.in_sel, r: b.result, u: b.upper_result,
              f: {b.sign_flag, b.modulo_flag, b.parity_flag, b.negative_flag,
                  b.zero_flag, b.overflow_flag, b.carry_flag}};
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(m_e);
      if (sticky_clr) st = 0;
      if (m_push) st = st | m_e.f;
      taken = m_push;
    end
  task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [6:0] exp_sticky(logic [6:0] v);
`ifdef ALU_STICKY_FLAGS_EN
    return v;
`else
    return 7'd0;
`endif
  endfunction
  // every cycle: registered outputs against the model
  always @(negedge clk) begin
    chk("out_valid", N'(b.out_valid), N'(q.size() != 0));
    chk("in_ready", N'(b.in_ready), N'(q.size() != DEPTH));
    chk("count", N'(count), N'(q.size()));
    chk("sticky", N'(sticky_flags), N'(exp_sticky(st)));
    if (q.size() != 0) begin
      chk("head_sel", N'(b.out_sel), N'(q[0].sel));
      chk("head_result", b.out_result, q[0].r);
      chk("head_upper", b.out_upper, q[0].u);
      chk("head_flags", N'(b.out_flags), N'(q[0].f));
    end
  end
  function automatic ent_t mk(int sel, longint r, longint u, int f);
    return '{sel: 6'(sel), r: N'(r), u: N'(u), f: 7'(f)};
  endfunction
  function automatic ent_t rnd();
    return '{sel: 6'($urandom_range(0, 34)), r: {$urandom, $urandom},
             u: {$urandom, $urandom}, f: 7'($urandom)};
  endfunction
  // one cycle of stimulus; a not-yet-accepted request is held unchanged
  task automatic cyc(bit v, bit ordy, bit clr, ent_t e);
    @(negedge clk);
    if (!(b.in_valid && !taken)) begin
      b.in_valid = v;
      b.in_sel = e.sel;
      b.result = e.r;
      b.upper_result = e.u;
      {b.sign_flag, b.modulo_flag, b.parity_flag, b.negative_flag,
       b.zero_flag, b.overflow_flag, b.carry_flag} = e.f;
    end
    b.out_ready = ordy;
    sticky_clr = clr;
  endtask
  task automatic rst_lits(string tag);
    chk({tag, "_count"}, N'(count), 0);
    chk({tag, "_out_valid"}, N'(b.out_valid), 0);
    chk({tag, "_in_ready"}, N'(b.in_ready), 1);
    chk({tag, "_out_result"}, b.out_result, 0);
    chk({tag, "_out_upper"}, b.out_upper, 0);
    chk({tag, "_out_flags"}, N'(b.out_flags), 0);
    chk({tag, "_out_sel"}, N'(b.out_sel), 0);
    chk({tag, "_sticky"}, N'(sticky_flags), 0);
  endtask
  ent_t z;
  initial begin
    z = '0;
    b.in_valid = 0; b.out_ready = 0; b.in_sel = 0; b.result = 0; b.upper_result = 0;
    {b.sign_flag, b.modulo_flag, b.parity_flag, b.negative_flag,
     b.zero_flag, b.overflow_flag, b.carry_flag} = 0;
    #12 rst_lits("reset");
    @(negedge clk) rst = 0;
    // single push then pop
    cyc(1, 0, 0, mk(0, 5, 0, 0));
    cyc(0, 1, 0, z);
    chk("single_valid", N'(b.out_valid), 1);
    chk("single_result", b.out_result, 5);
    chk("single_count", N'(count), 1);
    cyc(0, 0, 0, z);
    chk("single_pop_count", N'(count), 0);
    chk("single_pop_valid", N'(b.out_valid), 0);
    // overfill with consumer stalled, then drain
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, mk(i, i, 100 + i, i));
    cyc(1, 0, 0, z);
    chk("fill_count", N'(count), 4);
    chk("fill_in_ready", N'(b.in_ready), 0);
    cyc(0, 1, 0, z);
    chk("fill_head", b.out_result, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, z);
    cyc(0, 0, 0, z);
    chk("drain_count", N'(count), 0);
    // continuous push+pop at count 2
    cyc(1, 0, 0, rnd());
    cyc(1, 0, 0, rnd());
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, rnd());
    cyc(0, 0, 0, z);
    chk("stream_count", N'(count), 2);
    cyc(0, 1, 0, z);
    cyc(0, 1, 0, z);
    // full with pop and push together: push refused that cycle
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, rnd());
    cyc(1, 1, 0, mk(9, 9, 9, 0));
    chk("full_count", N'(count), 4);
    cyc(1, 0, 0, z);
    chk("full_pop_refuse", N'(count), 3);
    cyc(0, 0, 0, z);
    chk("full_push_next", N'(count), 4);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, z);
    // sticky accumulation and clear-with-push
    cyc(0, 1, 1, z);
    cyc(1, 1, 0, mk(1, 0, 0, 7'b0000001));
    cyc(1, 1, 0, mk(2, 0, 0, 7'b0000010));
    cyc(0, 1, 0, z);
    chk("sticky_or", N'(sticky_flags), N'(exp_sticky(7'b0000011)));
    cyc(1, 1, 1, mk(3, 0, 0, 7'b0000100));
    cyc(0, 1, 0, z);
    chk("sticky_clr_push", N'(sticky_flags), N'(exp_sticky(7'b0000100)));
    // asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, rnd());
    cyc(0, 0, 0, z);
    chk("pre_rst_count", N'(count), 3);
    #2 rst = 1;
    #1 rst_lits("async_rst");
    @(negedge clk) rst = 0;
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rnd());
    cyc(0, 1, 0, z);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
